pr_tick_counter: RTL
====================

PR_TICK_COUNTER -- requirements
Module: pr_tick_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter bit width per channel, at least 2.
REQ-002 Parameter CHANNELS, default 4: number of independent counter channels, at least 1.
REQ-003 Parameter TICKS, default 10000000: prescaler period in clk cycles, at least 2.
REQ-004 Parameter SYNC_STAGES, default 2: synchroniser depth for din, at least 2.
REQ-005 Port clk  input  1: single clock; all state rises on posedge clk.
REQ-006 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 Port din  input  CHANNELS: per-channel direction, asynchronous to clk (1 = count down, 0 = count up).
REQ-008 Port hold  input  CHANNELS: per-channel freeze, synchronous to clk.
REQ-009 Port load  input  1: synchronous load strobe.
REQ-010 Port load_val  input  WIDTH: value loaded into all channels.
REQ-011 Port dout  output  CHANNELS*WIDTH: channel c count at bits [c*WIDTH +: WIDTH], registered.
REQ-012 Port tick  output  1: one-cycle strobe, high in the cycle new dout values first appear.
REQ-013 Port wrap  output  CHANNELS: one-cycle per-channel strobe marking a wrap on the latest update.

Function
REQ-014 Prescaler p shall have width $clog2(TICKS) and count 0..TICKS-1, returning to 0 after TICKS-1.
REQ-015 The update edge shall be the posedge with p==TICKS-1, giving one update every TICKS cycles.
REQ-016 On the update edge, channel c with hold[c]=1 shall keep its count and clear wrap[c].
REQ-017 On the update edge, channel c in up mode: count==2^WIDTH-1 -> 0 with wrap[c]<=1; otherwise +1 with wrap[c]<=0.
REQ-018 On the update edge, channel c in down mode: count==0 -> 2^WIDTH-1 with wrap[c]<=1; otherwise -1 with wrap[c]<=0.
REQ-019 The mode shall be taken from the din[c] synchroniser output (last stage); din reaches counting logic SYNC_STAGES edges after capture.
REQ-020 tick shall be registered 1 on the update edge and 0 on every other edge; wrap shall be 0 on every non-update edge.
REQ-021 load=1 on any edge shall set every channel count to load_val, set p to 0, and clear tick and wrap.
REQ-022 load shall take priority over an update edge on the same clock; that update is discarded.
REQ-023 The first update after load shall occur TICKS edges after the load edge.
REQ-024 Arithmetic shall be modulo 2^WIDTH with no saturation; channels shall be fully independent apart from load and the shared prescaler.

Reset
REQ-025 rst_n=0 shall, without a clock edge, clear p, all counts (dout=0), tick, wrap and all synchroniser flops.
REQ-026 After rst_n deasserts, the first update edge shall be the TICKS-th posedge.
REQ-027 Reset asserted mid-period shall abandon the period; no partial update shall occur.

Structure
REQ-028 Package pr_tick_counter_pkg shall hold the direction encoding constants (DIR_UP=0, DIR_DOWN=1) and a function returning the prescaler width.
REQ-029 The per-bit synchroniser shall be a sub-module sync_ff (parameter STAGES, async active-low reset) instantiated CHANNELS times; prescaler and counters stay in pr_tick_counter.
REQ-030 The block shall keep all registers (KEEP/DONT_TOUCH attributes on counter and prescaler) so they survive reconfigurable-partition implementation.

Verification (WIDTH=4, CHANNELS=4, TICKS=4, SYNC_STAGES=2)
REQ-031 Reset release, din=0, hold=0: tick every 4th cycle; dout channel 0 runs 0,1,...,15,0; wrap[0]=1 only with the 15->0 update.
REQ-032 din[1]=1 held since reset: first update gives channel 1 0->15 with wrap[1]=1, then 14, 13, ... while other channels count up.
REQ-033 load=1 with load_val=7 two cycles into a period: next cycle all channels=7 and tick=0; next tick 4 edges after load; load coinciding with the update edge: still 7, tick=0.
REQ-034 hold[2]=1 across three updates: channel 2 constant and wrap[2]=0 while channels 0, 1, 3 advance.
REQ-035 din[3] toggled 1 edge before an update edge: that update uses the old direction; the following update uses the new one.
REQ-036 rst_n pulsed low between clock edges mid-period: dout, tick and wrap are 0 before the next posedge; first tick 4 edges after release.

Source files
------------

// File: rtl/pr_tick_counter_pkg.sv
// Shared constants for the prescaled multi-channel up/down tick counter.
package pr_tick_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Width of the prescaler that counts 0..ticks-1.
  function automatic int presc_width(input int ticks);
    return $clog2(ticks);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchroniser for a single asynchronous bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pr_tick_counter.sv
// CHANNELS independent modulo-2^WIDTH up/down counters advanced once every
// TICKS clocks by a shared prescaler; load overrides everything.
module pr_tick_counter
  import pr_tick_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int CHANNELS    = 4,
  parameter int TICKS       = 10000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       din,
  input  logic [CHANNELS-1:0]       hold,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_val,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      tick,
  output logic [CHANNELS-1:0]       wrap
);

  localparam int               PW      = presc_width(TICKS);
  localparam logic [PW-1:0]    P_LAST  = PW'(TICKS - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] dir;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (din[c]),
      .q_o   (dir[c])
    );
  end

  (* keep = "true", dont_touch = "true" *) logic [PW-1:0]    p_q;
  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] cnt_q [CHANNELS];
  logic [PW-1:0]       p_d;
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic                tick_q, tick_d;
  logic [CHANNELS-1:0] wrap_q, wrap_d;
  logic                upd;

  assign upd = (p_q == P_LAST);

  always_comb begin
    p_d    = upd ? '0 : p_q + 1'b1;
    tick_d = upd;
    wrap_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
    end
    // Load wins over a coinciding update edge; that update is simply dropped.
    if (load) begin
      p_d    = '0;
      tick_d = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_d[c] = load_val;
      end
    end else if (upd) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!hold[c]) begin
          if (dir[c] == DIR_UP) begin
            wrap_d[c] = (cnt_q[c] == CNT_MAX);
            cnt_d[c]  = cnt_q[c] + 1'b1;
          end else begin
            wrap_d[c] = (cnt_q[c] == '0);
            cnt_d[c]  = cnt_q[c] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      tick_q <= 1'b0;
      wrap_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      p_q    <= p_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_dout
    assign dout[c*WIDTH +: WIDTH] = cnt_q[c];
  end

  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule
